apb_master_bridge: RTL and testbench

Single-master APB3 bridge between the multi-cycle RV32I core's bus port and the on-chip peripherals. It accepts one load/store request at a time from the control unit (`transfer`/`busWe`) together with the datapath address and write data. It runs the APB SETUP/ACCESS sequence toward the addressed slave, then returns `ready` and read data so the core can leave its memory state. It also performs address decode into per-slave `PSEL` lines.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_addr_decoder.sv | 32 +++
 rtl/apb_master_bridge.sv | 154 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
// Optional ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] APB_TIMEOUT_DATA = 32'hDEAD_0BAD;
  localparam logic [31:0] APB_MISS_DATA    = 32'h0;

endpackage

// File: rtl/apb_addr_decoder.sv
// Peripheral window decode: byte address to one-hot slave select.
// Addresses below the window wrap to a large offset and miss.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned SLOT_BITS  = 12
) (
  input  logic [31:0]           addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  localparam int unsigned TW = 32 - SLOT_BITS;
  localparam logic [31:0] BASE = BASE_ADDR;

  logic [TW-1:0] diff;
  logic          unused_low;

  assign diff = addr[31:SLOT_BITS] - BASE[31:SLOT_BITS];
  assign unused_low = ^addr[SLOT_BITS-1:0];

  always_comb begin
    sel = '0;
    hit = ({{SLOT_BITS{1'b0}}, diff} < 32'(NUM_SLAVES));
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = hit && (diff == TW'(i));
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 single-master bridge for the multi-cycle core bus port.
// Define APB_TIMEOUT_EN to bound ACCESS waits and raise sticky err.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int unsigned SLOT_BITS      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     transfer,
  input  logic                     write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              PADDR,
  output logic [31:0]              PWDATA,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [NUM_SLAVES*32-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY
);

  apb_state_e state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic [31:0] rdata_q, rdata_d;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic        dec_hit;
  logic        pready_eff;
  logic [31:0] prdata_eff;
  logic [31:0] rd_now;
  logic        in_access;
  logic        timeout;

  apb_addr_decoder #(
    .NUM_SLAVES(NUM_SLAVES),
    .BASE_ADDR (BASE_ADDR),
    .SLOT_BITS (SLOT_BITS)
  ) u_dec (
    .addr(addr),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  assign in_access = (state_q == ACCESS);

  // A miss latches no select, so it completes as if PREADY were high.
  always_comb begin
    prdata_eff = APB_MISS_DATA;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) prdata_eff = prdata_eff | PRDATA[32*i +: 32];
    end
  end

  assign pready_eff = (psel_q == '0) | (|(psel_q & PREADY));

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign timeout = in_access && !pready_eff &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == SETUP) cnt_d = '0;
    else if (in_access && !pready_eff) cnt_d = cnt_q + CW'(1);
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign ready  = in_access && (pready_eff || timeout);
  assign rd_now = timeout ? APB_TIMEOUT_DATA : prdata_eff;
  assign rdata  = (ready && !pwrite_q) ? rd_now : rdata_q;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    psel_d   = psel_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          state_d  = SETUP;
          paddr_d  = addr;
          pwdata_d = wdata;
          pwrite_d = write;
          psel_d   = dec_hit ? dec_sel : '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (ready) begin
          state_d = IDLE;
          rdata_d = rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      psel_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      psel_q   <= psel_d;
      rdata_q  <= rdata_d;
    end
  end

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PENABLE = in_access;
  assign PSEL    = (state_q == IDLE) ? '0 : psel_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge.
// Timeout steps build only when APB_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  logic         clk;
  logic         reset;
  logic         transfer;
  logic         write;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         ready;
  logic         err;
  logic [31:0]  PADDR;
  logic [31:0]  PWDATA;
  logic         PWRITE;
  logic         PENABLE;
  logic [3:0]   PSEL;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;

  int ntests = 0;
  int nfail  = 0;

  apb_master_bridge dut (
    .clk     (clk),
    .reset   (reset),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] sel,
                         input logic en, input logic rdy);
    chk({tag, ".psel"}, 32'(PSEL), 32'(sel));
    chk({tag, ".penable"}, 32'(PENABLE), 32'(en));
    chk({tag, ".ready"}, 32'(ready), 32'(rdy));
  endtask

  initial begin
    reset    = 1'b1;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    PREADY   = 4'b1111;
    PRDATA   = {32'h3333_3333, 32'h2222_2222,
                32'h1111_1111, 32'h0000_0000};
    step();
    chk_bus("rst", 4'b0000, 1'b0, 1'b0);
    chk("rst.paddr", PADDR, 32'h0);
    chk("rst.pwdata", PWDATA, 32'h0);
    chk("rst.pwrite", 32'(PWRITE), 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    reset = 1'b0;
    step();

    // store to slave1, zero wait states
    transfer = 1'b1;
    write    = 1'b1;
    addr     = 32'h1000_1004;
    wdata    = 32'h1234_5678;
    #1;
    chk_bus("st.c1", 4'b0000, 1'b0, 1'b0);
    step();
    chk_bus("st.setup", 4'b0010, 1'b0, 1'b0);
    chk("st.paddr", PADDR, 32'h1000_1004);
    chk("st.pwdata", PWDATA, 32'h1234_5678);
    chk("st.pwrite", 32'(PWRITE), 32'h1);
    transfer = 1'b0;
    step();
    chk_bus("st.access", 4'b0010, 1'b1, 1'b1);
    chk("st.rdata", rdata, 32'h0);
    step();
    chk_bus("st.idle", 4'b0000, 1'b0, 1'b0);
    chk("st.paddr_hold", PADDR, 32'h1000_1004);

    // load from slave2 with two wait states
    PRDATA[95:64] = 32'hCAFE_F00D;
    PREADY   = 4'b1011;
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_2000;
    step();
    chk_bus("ld.setup", 4'b0100, 1'b0, 1'b0);
    chk("ld.pwrite", 32'(PWRITE), 32'h0);
    step();
    chk_bus("ld.wait1", 4'b0100, 1'b1, 1'b0);
    chk("ld.rdata_w1", rdata, 32'h0);
    step();
    chk_bus("ld.wait2", 4'b0100, 1'b1, 1'b0);
    step();
    PREADY = 4'b1111;
    #1;
    chk_bus("ld.done", 4'b0100, 1'b1, 1'b1);
    chk("ld.rdata_comb", rdata, 32'hCAFE_F00D);
    transfer = 1'b0;
    step();
    chk_bus("ld.idle", 4'b0000, 1'b0, 1'b0);
    PRDATA[95:64] = 32'h5555_AAAA;
    #1;
    chk("ld.rdata_hold", rdata, 32'hCAFE_F00D);

    // store to slave3 leaves held load data alone
    transfer = 1'b1;
    write    = 1'b1;
    addr     = 32'h1000_3FFC;
    wdata    = 32'hA5A5_0001;
    step();
    chk("st3.psel", 32'(PSEL), 32'h8);
    transfer = 1'b0;
    step();
    chk("st3.ready", 32'(ready), 32'h1);
    chk("st3.rdata", rdata, 32'hCAFE_F00D);
    step();
    chk("st3.rdata_idle", rdata, 32'hCAFE_F00D);

    // unmapped load completes in minimum time with zero data
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h2000_0000;
    PREADY   = 4'b0000;
    step();
    chk_bus("miss.setup", 4'b0000, 1'b0, 1'b0);
    transfer = 1'b0;
    step();
    chk_bus("miss.access", 4'b0000, 1'b1, 1'b1);
    chk("miss.rdata", rdata, 32'h0);
    step();
    chk("miss.rdata_hold", rdata, 32'h0);

    // one slot past the last slave, and just below the window
    PRDATA[31:0] = 32'h0BAD_BEEF;
    transfer = 1'b1;
    addr     = 32'h1000_4000;
    step();
    chk("edge_hi.psel", 32'(PSEL), 32'h0);
    transfer = 1'b0;
    step();
    chk("edge_hi.ready", 32'(ready), 32'h1);
    step();
    transfer = 1'b1;
    addr     = 32'h0FFF_FFFC;
    step();
    chk("edge_lo.psel", 32'(PSEL), 32'h0);
    transfer = 1'b0;
    step();
    chk("edge_lo.ready", 32'(ready), 32'h1);
    chk("edge_lo.rdata", rdata, 32'h0);
    step();

    // transfer held across completion: must revisit IDLE
    PREADY   = 4'b1111;
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_0010;
    step();
    chk_bus("hold.setup", 4'b0001, 1'b0, 1'b0);
    step();
    chk_bus("hold.access", 4'b0001, 1'b1, 1'b1);
    chk("hold.rdata", rdata, 32'h0BAD_BEEF);
    step();
    chk_bus("hold.idle", 4'b0000, 1'b0, 1'b0);
    step();
    chk_bus("hold.setup2", 4'b0001, 1'b0, 1'b0);
    transfer = 1'b0;
    step();
    chk_bus("hold.access2", 4'b0001, 1'b1, 1'b1);
    step();
    step();
    chk_bus("hold.quiet", 4'b0000, 1'b0, 1'b0);

    // reset during a stalled ACCESS
    PREADY   = 4'b1101;
    transfer = 1'b1;
    write    = 1'b1;
    addr     = 32'h1000_1000;
    wdata    = 32'h7777_7777;
    step();
    transfer = 1'b0;
    step();
    chk_bus("rma.access", 4'b0010, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_bus("rma.async", 4'b0000, 1'b0, 1'b0);
    chk("rma.paddr", PADDR, 32'h0);
    chk("rma.rdata", rdata, 32'h0);
    reset = 1'b0;
    step();
    chk_bus("rma.idle1", 4'b0000, 1'b0, 1'b0);
    PREADY = 4'b1111;
    step();
    chk_bus("rma.idle2", 4'b0000, 1'b0, 1'b0);

`ifdef APB_TIMEOUT_EN
    // slave3 never answers: forced completion after 16 ACCESS cycles
    PREADY   = 4'b0111;
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_3000;
    step();
    transfer = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("to.wait", 32'(ready), 32'h0);
    end
    step();
    chk_bus("to.fire", 4'b1000, 1'b1, 1'b1);
    chk("to.rdata", rdata, 32'hDEAD_0BAD);
    step();
    chk_bus("to.idle", 4'b0000, 1'b0, 1'b0);
    chk("to.err", 32'(err), 32'h1);
    chk("to.rdata_hold", rdata, 32'hDEAD_0BAD);
    PREADY   = 4'b1111;
    transfer = 1'b1;
    addr     = 32'h1000_2000;
    step();
    transfer = 1'b0;
    step();
    chk("to.next_ready", 32'(ready), 32'h1);
    chk("to.next_rdata", rdata, 32'h5555_AAAA);
    step();
    chk("to.err_sticky", 32'(err), 32'h1);
`else
    // without the timeout the bridge waits indefinitely
    PREADY   = 4'b0111;
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_3000;
    step();
    transfer = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("nto.wait", 32'(ready), 32'h0);
    end
    chk("nto.err", 32'(err), 32'h0);
    PREADY = 4'b1111;
    #1;
    chk("nto.done", 32'(ready), 32'h1);
    chk("nto.rdata", rdata, 32'h3333_3333);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
